// File: rtl/key_arbiter_if.sv
// key_arbiter_if: groups the keyboard byte stream, the frame slot pulse and the
// command handshake toward the game FSM.
//   done       - PS/2 receiver byte-complete level (new byte on 0->1)
//   tasta      - received scan-code byte, valid when done rises
//   frame_tick - one-cycle pulse opening one arbitration slot per frame
//   cmd_ready  - game FSM accepts the offered command
//   cmd_valid  - a command is being offered
//   cmd_code   - offered command (0 ESC .. 7 P2_RIGHT)
//   held_keys  - held bitmap [7:0] = 2,1,SPACE,ESC,P2R,P2L,P1R,P1L
interface key_arbiter_if;
  logic       done;
  logic [7:0] tasta;
  logic       frame_tick;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [7:0] held_keys;

  // master drives the keyboard/frame/ready side; slave is the arbiter
  modport master (
    output done, tasta, frame_tick, cmd_ready,
    input  cmd_valid, cmd_code, held_keys
  );

  modport slave (
    input  done, tasta, frame_tick, cmd_ready,
    output cmd_valid, cmd_code, held_keys
  );
endinterface

// File: rtl/key_arbiter.sv
// key_arbiter: decodes PS/2 scan codes into a held-key bitmap plus one-shot
// control requests, and offers at most one command per video frame to the
// game FSM over a valid/ready handshake.
//   clock  - system clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - key_arbiter_if slave modport (done, tasta, frame_tick, cmd_ready in;
//            cmd_valid, cmd_code, held_keys out)
module key_arbiter (
  input  logic          clock,
  input  logic          reset,
  key_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  // done edge detection
  logic       done_q;
  logic       seen_low_q;   // done observed low since reset; blocks a stale high level
  logic       strobe_q;
  logic       strobe_d;
  logic [7:0] byte_q;
  logic [7:0] byte_d;
  logic       rise;

  // decoder state
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic [7:0] held_q, held_d;
  logic [3:0] pend_q, pend_d;   // [0] ESC, [1] SPACE, [2] MODE1, [3] MODE2
  logic [3:0] pend_set;
  logic [3:0] pend_clr;
  logic [7:0] key_bit;

  // arbitration / offer state
  state_e     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       rr_q, rr_d;       // 0 prefers player 1, 1 prefers player 2
  logic       req_p1, req_p2;
  logic       grant_valid;
  logic       grant_move;
  logic       grant_p2;
  logic [2:0] grant_code;

  assign rise     = bus.done & ~done_q & seen_low_q;
  assign strobe_d = rise;
  assign byte_d   = rise ? bus.tasta : byte_q;

  // Scan code to held-bitmap position; unmapped codes give zero.
  always_comb begin
    key_bit = 8'h00;
    case (byte_q)
      8'h1C:   key_bit = 8'h01;  // P1L
      8'h23:   key_bit = 8'h02;  // P1R
      8'h3B:   key_bit = 8'h04;  // P2L
      8'h4B:   key_bit = 8'h08;  // P2R
      8'h76:   key_bit = 8'h10;  // ESC
      8'h29:   key_bit = 8'h20;  // SPACE
      8'h16:   key_bit = 8'h40;  // key 1
      8'h1E:   key_bit = 8'h80;  // key 2
      default: key_bit = 8'h00;
    endcase
  end

  // Byte decoder: prefixes arm flags, key codes update the bitmap.
  always_comb begin
    brk_d    = brk_q;
    ext_d    = ext_q;
    held_d   = held_q;
    pend_set = 4'b0000;
    if (strobe_q) begin
      if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!ext_q) begin
          if (brk_q) begin
            held_d = held_q & ~key_bit;
          end else begin
            held_d   = held_q | key_bit;
            // only a fresh press arms a one-shot, typematic repeats do not
            pend_set = key_bit[7:4] & ~held_q[7:4];
          end
        end
      end
    end
  end

  // Fixed-priority grant from pre-edge state; movement is round-robin.
  assign req_p1 = held_q[0] ^ held_q[1];
  assign req_p2 = held_q[2] ^ held_q[3];

  always_comb begin
    grant_valid = 1'b1;
    grant_move  = 1'b0;
    grant_p2    = 1'b0;
    grant_code  = 3'd0;
    if (pend_q[0]) begin
      grant_code = 3'd0;
    end else if (pend_q[1]) begin
      grant_code = 3'd1;
    end else if (pend_q[2]) begin
      grant_code = 3'd2;
    end else if (pend_q[3]) begin
      grant_code = 3'd3;
    end else if (req_p1 && (!req_p2 || !rr_q)) begin
      grant_move = 1'b1;
      grant_code = {2'b10, held_q[1]};
    end else if (req_p2) begin
      grant_move = 1'b1;
      grant_p2   = 1'b1;
      grant_code = {2'b11, held_q[3]};
    end else begin
      grant_valid = 1'b0;
    end
  end

  // Offer FSM: idle until a slot grants, hold the offer until accepted.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    rr_d     = rr_q;
    pend_clr = 4'b0000;
    unique case (state_q)
      StIdle: begin
        if (bus.frame_tick && grant_valid) begin
          state_d = StOffer;
          code_d  = grant_code;
          if (grant_move) begin
            rr_d = ~grant_p2;
          end
        end
      end
      StOffer: begin
        if (bus.cmd_ready) begin
          state_d = StIdle;
          if (!code_q[2]) begin
            pend_clr[code_q[1:0]] = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // a press landing in the same cycle as an accept keeps its flag
  assign pend_d = (pend_q & ~pend_clr) | pend_set;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_q     <= 1'b0;
      seen_low_q <= 1'b0;
      strobe_q   <= 1'b0;
      byte_q     <= 8'h00;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      held_q     <= 8'h00;
      pend_q     <= 4'b0000;
      state_q    <= StIdle;
      code_q     <= 3'd0;
      rr_q       <= 1'b0;
    end else begin
      done_q     <= bus.done;
      seen_low_q <= seen_low_q | ~bus.done;
      strobe_q   <= strobe_d;
      byte_q     <= byte_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      held_q     <= held_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      code_q     <= code_d;
      rr_q       <= rr_d;
    end
  end

  assign bus.cmd_valid = (state_q == StOffer);
  assign bus.cmd_code  = code_q;
  assign bus.held_keys = held_q;

endmodule

// File: tb/tb_key_arbiter.sv
// tb_key_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the key arbiter.
module tb_key_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;

  key_arbiter_if kif ();

  key_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (kif)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_prev_done, m_seen_low, m_strb;
  bit [7:0] m_byte;
  bit       m_brk, m_ext;
  bit       m_held[8];
  bit       m_pend[4];
  bit       m_ptr;       // 0 -> player 1 preferred
  bit       m_off;
  int       m_code;

  function automatic int key_index(input bit [7:0] b);
    case (b)
      8'h1C: return 0;
      8'h23: return 1;
      8'h3B: return 2;
      8'h4B: return 3;
      8'h76: return 4;
      8'h29: return 5;
      8'h16: return 6;
      8'h1E: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic int held_vec();
    int v = 0;
    for (int i = 0; i < 8; i++) if (m_held[i]) v += (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    m_prev_done = 0; m_seen_low = 0; m_strb = 0; m_byte = 0;
    m_brk = 0; m_ext = 0; m_ptr = 0; m_off = 0; m_code = 0;
    for (int i = 0; i < 8; i++) m_held[i] = 0;
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
  endtask

  task automatic model_step();
    int g;
    int k;
    bit r1, r2, acc, slot;
    g    = -1;
    acc  = m_off && kif.cmd_ready;
    slot = kif.frame_tick && !m_off;
    if (slot) begin
      for (int i = 0; i < 4; i++) if (m_pend[i] && g < 0) g = i;
      if (g < 0) begin
        r1 = (m_held[0] != m_held[1]);
        r2 = (m_held[2] != m_held[3]);
        if (r1 && (!r2 || !m_ptr)) begin
          g = m_held[1] ? 5 : 4;
          m_ptr = 1;
        end else if (r2) begin
          g = m_held[3] ? 7 : 6;
          m_ptr = 0;
        end
      end
    end
    if (acc) begin
      if (m_code < 4) m_pend[m_code] = 0;
      m_off = 0;
    end
    if (g >= 0) begin
      m_off  = 1;
      m_code = g;
    end
    if (m_strb) begin
      if (m_byte == 8'hF0) m_brk = 1;
      else if (m_byte == 8'hE0) m_ext = 1;
      else begin
        k = key_index(m_byte);
        if (!m_ext && k >= 0) begin
          if (m_brk) m_held[k] = 0;
          else begin
            if (k >= 4 && !m_held[k]) m_pend[k-4] = 1;
            m_held[k] = 1;
          end
        end
        m_brk = 0;
        m_ext = 0;
      end
    end
    m_strb      = kif.done && !m_prev_done && m_seen_low;
    m_byte      = kif.tasta;
    m_prev_done = kif.done;
    if (!kif.done) m_seen_low = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clock);
      check("cmd_valid", int'(kif.cmd_valid), int'(m_off));
      if (m_off || !reset) check("cmd_code", int'(kif.cmd_code), m_code);
      check("held_keys", int'(kif.held_keys), held_vec());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic send(input logic [7:0] b);
    kif.tasta = b;
    kif.done  = 1'b1;
    cyc(2);
    kif.done  = 1'b0;
    cyc(2);
  endtask

  task automatic tick();
    kif.frame_tick = 1'b1;
    cyc(1);
    kif.frame_tick = 1'b0;
  endtask

  task automatic accept();
    kif.cmd_ready = 1'b1;
    cyc(1);
    kif.cmd_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] tbl [12] = '{8'hF0, 8'hF0, 8'hE0, 8'h1C, 8'h23, 8'h3B,
                             8'h4B, 8'h76, 8'h29, 8'h16, 8'h1E, 8'hF0};
    int idx = $urandom_range(0, 12);
    if (idx == 12) return 8'($urandom_range(0, 255));
    return tbl[idx];
  endfunction

  int exp2 [4] = '{4, 7, 4, 7};
  int exp4 [4] = '{0, 1, 5, 5};

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    kif.done = 1'b0; kif.tasta = 8'h00; kif.frame_tick = 1'b0; kif.cmd_ready = 1'b0;
    cyc(3);
    check("reset_valid", int'(kif.cmd_valid), 0);
    check("reset_held", int'(kif.held_keys), 0);
    reset = 1'b1;
    cyc(2);

    // stale done high across reset release must not produce a byte
    reset = 1'b0;
    kif.tasta = 8'h1C;
    kif.done  = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(4);
    check("stale_done_held", int'(kif.held_keys), 0);
    kif.done = 1'b0;
    cyc(2);

    // scenario 1: press+release SPACE, one command then nothing
    do_reset();
    send(8'h29);
    check("s1_make_held", int'(kif.held_keys), 8'h20);
    send(8'hF0);
    send(8'h29);
    check("s1_brk_held", int'(kif.held_keys), 0);
    tick();
    check("s1_valid", int'(kif.cmd_valid), 1);
    check("s1_code", int'(kif.cmd_code), 1);
    accept();
    check("s1_accepted", int'(kif.cmd_valid), 0);
    tick();
    check("s1_no_repeat", int'(kif.cmd_valid), 0);

    // scenario 2: round-robin movement
    do_reset();
    send(8'h1C);
    send(8'h4B);
    check("s2_held", int'(kif.held_keys), 8'h09);
    kif.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s2_valid", int'(kif.cmd_valid), 1);
      check("s2_code", int'(kif.cmd_code), exp2[i]);
      cyc(2);
    end
    kif.cmd_ready = 1'b0;

    // scenario 3: typematic repeats give one SPACE
    do_reset();
    send(8'h29); send(8'h29); send(8'h29);
    send(8'hF0); send(8'h29);
    tick();
    check("s3_code", int'(kif.cmd_code), 1);
    accept();
    tick();
    check("s3_once_a", int'(kif.cmd_valid), 0);
    tick();
    check("s3_once_b", int'(kif.cmd_valid), 0);

    // scenario 4: priority ESC > SPACE > movement
    do_reset();
    send(8'h76); send(8'h29); send(8'h23);
    check("s4_held", int'(kif.held_keys), 8'h32);
    kif.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s4_code", int'(kif.cmd_code), exp4[i]);
      cyc(2);
    end
    kif.cmd_ready = 1'b0;

    // scenario 5: offer held across ticks while not ready
    do_reset();
    send(8'h76); send(8'h3B);
    tick();
    check("s5_code", int'(kif.cmd_code), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      tick();
      check("s5_hold_valid", int'(kif.cmd_valid), 1);
      check("s5_hold_code", int'(kif.cmd_code), 0);
    end
    accept();
    check("s5_accepted", int'(kif.cmd_valid), 0);
    tick();
    check("s5_fresh_code", int'(kif.cmd_code), 6);

    // scenario 6: extended code discarded, break flag cleared by reset
    do_reset();
    send(8'hE0); send(8'h1C);
    check("s6_ext_held", int'(kif.held_keys), 0);
    send(8'hF0);
    do_reset();
    send(8'h1C);
    check("s6_held", int'(kif.held_keys), 8'h01);

    // reset mid-offer drops the command
    do_reset();
    send(8'h76);
    tick();
    do_reset();
    check("rst_offer_valid", int'(kif.cmd_valid), 0);
    tick();
    check("rst_offer_none", int'(kif.cmd_valid), 0);

    // byte strobe coinciding with frame_tick does not feed that slot
    do_reset();
    kif.tasta = 8'h76;
    kif.done  = 1'b1;
    cyc(1);
    kif.frame_tick = 1'b1;
    cyc(1);
    kif.frame_tick = 1'b0;
    check("coinc_valid", int'(kif.cmd_valid), 0);
    check("coinc_held", int'(kif.held_keys), 8'h10);
    kif.done = 1'b0;
    cyc(2);
    tick();
    check("coinc_next_code", int'(kif.cmd_code), 0);
    cyc(1);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      kif.frame_tick = ($urandom_range(0, 5) == 0);
      kif.cmd_ready  = ($urandom_range(0, 2) == 0);
      if (!kif.done) begin
        if ($urandom_range(0, 2) == 0) begin
          kif.tasta = pick();
          kif.done  = 1'b1;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        kif.done = 1'b0;
      end
      reset = ($urandom_range(0, 399) != 0);
      cyc(1);
    end

    kif.frame_tick = 1'b0;
    kif.cmd_ready  = 1'b0;
    reset          = 1'b1;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
